// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants and state encoding for the register-file port arbiter.
package regfile_port_arbiter_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned NREG   = 32;

    // X31 reads as zero in the register file; init never writes it.
    localparam logic [4:0] XZR_IDX = 5'd31;

    // Last index cleared by the init sweep (X0..X30).
    localparam logic [4:0] INIT_LAST = 5'(NREG - 2);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DBG  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_port_arbiter.sv
// Owns the register file select/write ports: clears X0-X30 after reset,
// then passes datapath traffic through, stealing one stalled cycle per
// debug read or write.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [4:0]        DpReadSelect1,
    input  logic [4:0]        DpReadSelect2,
    input  logic [4:0]        DpWriteSelect,
    input  logic [DATA_W-1:0] DpWriteData,
    input  logic              DpRegWrite,
    input  logic              DbgReq,
    input  logic              DbgWrite,
    input  logic [4:0]        DbgAddr,
    input  logic [DATA_W-1:0] DbgWData,
    output logic              DbgAck,
    output logic [DATA_W-1:0] DbgRData,
    output logic [4:0]        RfReadSelect1,
    output logic [4:0]        RfReadSelect2,
    output logic [4:0]        RfWriteSelect,
    output logic [DATA_W-1:0] RfWriteData,
    output logic              RfRegWrite,
    input  logic [DATA_W-1:0] RfReadData1,
    output logic              Stall,
    output logic              InitDone
);

    state_t              state;
    state_t              next_state;
    logic [4:0]          init_idx;
    logic                lat_write;
    logic [4:0]          lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    // Next-state decision; the init sweep ends on equality so it never wraps.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_INIT: if (init_idx == INIT_LAST) next_state = ST_RUN;
            ST_RUN:  if (DbgReq)                next_state = ST_DBG;
            ST_DBG:                             next_state = ST_ACK;
            ST_ACK:  if (!DbgReq)               next_state = ST_RUN;
            default:                            next_state = ST_INIT;
        endcase
    end

    // State, init counter, request latches and registered debug outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_INIT;
            init_idx  <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            DbgAck    <= 1'b0;
            DbgRData  <= '0;
            InitDone  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_INIT && init_idx != INIT_LAST) begin
                init_idx <= init_idx + 5'd1;
            end
            if (state == ST_RUN && DbgReq) begin
                lat_write <= DbgWrite;
                lat_addr  <= DbgAddr;
                lat_wdata <= DbgWData;
            end
            if (state == ST_DBG && !lat_write) begin
                DbgRData <= RfReadData1;
            end
            DbgAck   <= (next_state == ST_ACK);
            InitDone <= (next_state != ST_INIT);
        end
    end

    // Port steering: passthrough by default, overridden during init and debug.
    always_comb begin
        RfReadSelect1 = DpReadSelect1;
        RfReadSelect2 = DpReadSelect2;
        RfWriteSelect = DpWriteSelect;
        RfWriteData   = DpWriteData;
        RfRegWrite    = DpRegWrite;
        Stall         = 1'b0;
        unique case (state)
            ST_INIT: begin
                RfWriteSelect = init_idx;
                RfWriteData   = '0;
                RfRegWrite    = 1'b1;
                Stall         = 1'b1;
            end
            ST_DBG: begin
                RfReadSelect1 = lat_addr;
                RfWriteSelect = lat_addr;
                RfWriteData   = lat_wdata;
                RfRegWrite    = lat_write;
                Stall         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural register file.
module tb_regfile_port_arbiter;
    import regfile_port_arbiter_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [4:0]        DpReadSelect1 = '0;
    logic [4:0]        DpReadSelect2 = '0;
    logic [4:0]        DpWriteSelect = '0;
    logic [DATA_W-1:0] DpWriteData = '0;
    logic              DpRegWrite = 1'b0;
    logic              DbgReq = 1'b0;
    logic              DbgWrite = 1'b0;
    logic [4:0]        DbgAddr = '0;
    logic [DATA_W-1:0] DbgWData = '0;
    logic              DbgAck;
    logic [DATA_W-1:0] DbgRData;
    logic [4:0]        RfReadSelect1;
    logic [4:0]        RfReadSelect2;
    logic [4:0]        RfWriteSelect;
    logic [DATA_W-1:0] RfWriteData;
    logic              RfRegWrite;
    logic [DATA_W-1:0] RfReadData1;
    logic              Stall;
    logic              InitDone;

    regfile_port_arbiter dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .DpReadSelect1 (DpReadSelect1),
        .DpReadSelect2 (DpReadSelect2),
        .DpWriteSelect (DpWriteSelect),
        .DpWriteData   (DpWriteData),
        .DpRegWrite    (DpRegWrite),
        .DbgReq        (DbgReq),
        .DbgWrite      (DbgWrite),
        .DbgAddr       (DbgAddr),
        .DbgWData      (DbgWData),
        .DbgAck        (DbgAck),
        .DbgRData      (DbgRData),
        .RfReadSelect1 (RfReadSelect1),
        .RfReadSelect2 (RfReadSelect2),
        .RfWriteSelect (RfWriteSelect),
        .RfWriteData   (RfWriteData),
        .RfRegWrite    (RfRegWrite),
        .RfReadData1   (RfReadData1),
        .Stall         (Stall),
        .InitDone      (InitDone)
    );

    always #5 Clk = ~Clk;

    // Behavioural register file: XZR reads zero and ignores writes.
    logic [63:0] rf [32];
    always @(posedge Clk) begin
        if (RfRegWrite && RfWriteSelect != XZR_IDX) rf[RfWriteSelect] <= RfWriteData;
    end
    assign RfReadData1 = (RfReadSelect1 == XZR_IDX) ? 64'd0 : rf[RfReadSelect1];

    typedef struct packed {
        logic [4:0]  sel;
        logic [63:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [63:0] rq[$];
    logic [63:0] shadow [32];
    logic [63:0] exp_rdata;
    logic        ack_prev = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_wr(input logic [4:0] s, input logic [63:0] d);
        wq.push_back({s, d});
        if (s != XZR_IDX) shadow[s] = d;
    endtask

    // Hold reset across n edges, then expect the X0..X30 clear sweep.
    task automatic do_reset(input int n);
        Reset = 1'b1;
        DbgReq = 1'b0;
        DpRegWrite = 1'b0;
        wq.delete();
        rq.delete();
        for (int i = 0; i < n; i++) step();
        Reset = 1'b0;
        shadow[31] = 64'd0;
        for (int i = 0; i < 31; i++) push_wr(5'(i), 64'd0);
        exp_rdata = 64'd0;
    endtask

    // Monitor: every register-file write and every debug completion is scored.
    always @(negedge Clk) begin
        if (Reset) begin
            ack_prev = 1'b0;
        end else begin
            if (RfRegWrite) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 64'(RfRegWrite), 64'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_sel", 64'(RfWriteSelect), 64'(e.sel));
                    check("wr_data", RfWriteData, e.data);
                end
            end
            if (DbgAck && !ack_prev) begin
                if (rq.size() == 0) check("ack_unexpected", 64'(DbgAck), 64'd0);
                else check("dbg_rdata", DbgRData, rq.pop_front());
            end
            ack_prev = DbgAck;
        end
    end

    // One debug access from RUN; the datapath may write X7 in non-stall cycles.
    task automatic dbg_access(input logic wr, input logic [4:0] addr,
                              input logic [63:0] wdata, input int hold, input logic dp_wr);
        logic [63:0] dpd;
        dpd = {$urandom, $urandom};
        DbgReq = 1'b1;
        DbgWrite = wr;
        DbgAddr = addr;
        DbgWData = wdata;
        DpWriteSelect = 5'd7;
        DpWriteData = dpd;
        DpRegWrite = dp_wr;
        if (dp_wr) push_wr(5'd7, dpd);
        @(negedge Clk);
        check("run_stall", 64'(Stall), 64'd0);
        check("run_ack", 64'(DbgAck), 64'd0);
        step();
        if (wr) push_wr(addr, wdata);
        else exp_rdata = shadow[addr];
        rq.push_back(exp_rdata);
        @(negedge Clk);
        check("dbg_stall", 64'(Stall), 64'd1);
        check("dbg_ack", 64'(DbgAck), 64'd0);
        if (!wr) check("dbg_rsel1", 64'(RfReadSelect1), 64'(addr));
        for (int h = 0; h <= hold; h++) begin
            step();
            if (dp_wr) push_wr(5'd7, dpd);
            @(negedge Clk);
            check("ack_high", 64'(DbgAck), 64'd1);
            check("ack_stall", 64'(Stall), 64'd0);
        end
        step();
        DbgReq = 1'b0;
        if (dp_wr) push_wr(5'd7, dpd);
        @(negedge Clk);
        check("ack_hold", 64'(DbgAck), 64'd1);
        step();
        DpRegWrite = 1'b0;
        @(negedge Clk);
        check("ack_drop", 64'(DbgAck), 64'd0);
        check("ret_stall", 64'(Stall), 64'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Clear sweep and InitDone timing.
        do_reset(2);
        DpReadSelect1 = 5'd9;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            check("init_stall", 64'(Stall), 64'(c <= 31));
            check("init_done", 64'(InitDone), 64'(c >= 32));
            if (c >= 32) check("rd_sel1_pass", 64'(RfReadSelect1), 64'd9);
            step();
        end
        check("init_drained", 64'(wq.size()), 64'd0);

        // Debug write, read-back with datapath write blocked in DBG, long hold.
        dbg_access(1'b1, 5'd5, 64'hDEAD_BEEF, 0, 1'b0);
        dbg_access(1'b0, 5'd5, 64'd0, 1, 1'b1);
        dbg_access(1'b0, 5'd7, 64'd0, 5, 1'b1);
        dbg_access(1'b1, 5'd31, 64'h1234, 0, 1'b0);
        dbg_access(1'b0, 5'd31, 64'd0, 0, 1'b0);

        // Request raised mid-init waits for RUN; X7 must read back cleared.
        do_reset(1);
        for (int c = 1; c <= 31; c++) begin
            if (c == 10) begin
                DbgReq = 1'b1;
                DbgWrite = 1'b0;
                DbgAddr = 5'd7;
            end
            @(negedge Clk);
            check("held_stall", 64'(Stall), 64'd1);
            check("held_ack", 64'(DbgAck), 64'd0);
            step();
        end
        exp_rdata = shadow[7];
        rq.push_back(exp_rdata);
        @(negedge Clk);
        check("held_initdone", 64'(InitDone), 64'd1);
        check("held_run_stall", 64'(Stall), 64'd0);
        step();
        @(negedge Clk);
        check("held_dbg_stall", 64'(Stall), 64'd1);
        step();
        DbgReq = 1'b0;
        @(negedge Clk);
        check("held_ack_high", 64'(DbgAck), 64'd1);
        step();
        @(negedge Clk);
        check("held_ack_drop", 64'(DbgAck), 64'd0);
        step();

        // Reset during DBG discards the access and restarts the sweep.
        dbg_access(1'b1, 5'd3, 64'hA5A5_A5A5, 0, 1'b0);
        dbg_access(1'b0, 5'd3, 64'd0, 0, 1'b0);
        DbgReq = 1'b1;
        DbgWrite = 1'b0;
        DbgAddr = 5'd3;
        step();
        @(negedge Clk);
        check("rst_dbg_stall", 64'(Stall), 64'd1);
        do_reset(1);
        @(negedge Clk);
        check("rst_ack", 64'(DbgAck), 64'd0);
        check("rst_rdata", DbgRData, 64'd0);
        check("rst_stall", 64'(Stall), 64'd1);
        check("rst_idx0", 64'(RfWriteSelect), 64'd0);
        check("rst_initdone", 64'(InitDone), 64'd0);
        step();
        for (int c = 2; c <= 31; c++) begin
            @(negedge Clk);
            check("rst_sweep_stall", 64'(Stall), 64'd1);
            step();
        end
        @(negedge Clk);
        check("rst_sweep_done", 64'(InitDone), 64'd1);
        step();

        check("wq_drained", 64'(wq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Sequential owner of the register file's select/write ports in the single-cycle LEGv8 datapath. Sits between the instruction-derived select mux (ReadSelect1/ReadSelect2/WriteSelect) and the register file. After reset it clears X0–X30, then passes datapath traffic through. It interleaves single-register debug reads and writes by stalling the PC for one cycle per access.

## Interface
- DATA_W, 64, register data width
- NREG, 32, architectural registers; index NREG-1 (X31/XZR) is never written by init
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- DpReadSelect1, DpReadSelect2, DpWriteSelect  in  5  datapath register indices
- DpWriteData  in  DATA_W  datapath writeback data
- DpRegWrite  in  1  datapath write enable
- DbgReq  in  1  debug request, four-phase handshake level
- DbgWrite  in  1  1 = write, 0 = read; sampled with DbgReq
- DbgAddr  in  5  debug register index
- DbgWData  in  DATA_W  debug write data
- DbgAck  out  1  access complete; held until DbgReq falls
- DbgRData  out  DATA_W  registered read result, valid while DbgAck=1
- RfReadSelect1, RfReadSelect2, RfWriteSelect  out  5  to register file
- RfWriteData  out  DATA_W  to register file
- RfRegWrite  out  1  to register file
- RfReadData1  in  DATA_W  register file port-1 read data (combinational)
- Stall  out  1  holds PC/instruction fetch when 1
- InitDone  out  1  high once in RUN or later states

## Operation
- States: INIT, RUN, DBG, ACK.
- INIT: 5-bit counter InitIdx = 0..NREG-2. Drives RfWriteSelect=InitIdx, RfWriteData=0, RfRegWrite=1, Stall=1. Datapath inputs are ignored. On InitIdx=NREG-2, go to RUN next cycle.
- RUN: pure passthrough of Dp* to Rf*, Stall=0. If DbgReq=1, the current datapath instruction still completes this cycle. Latch DbgWrite/DbgAddr/DbgWData and go to DBG.
- DBG (exactly 1 cycle): Stall=1.
  - RfReadSelect1=latched addr. RfReadSelect2=DpReadSelect2, don't-care.
  - RfWriteSelect=latched addr, RfWriteData=latched wdata, RfRegWrite=latched write.
  - Datapath DpRegWrite is suppressed.
  - On a read, capture RfReadData1 into DbgRData at end of cycle. On a write, DbgRData keeps its old value.
  - Next state is ACK.
- ACK: DbgAck=1, Stall=0, Dp* passthrough as in RUN. When DbgReq=0, go to RUN. New requests are not accepted until back in RUN.
- Debug write to index 31 is passed to the register file unchanged; XZR semantics belong to the register file.
- DbgReq during INIT is held off and serviced on the first RUN cycle.

## Timing
- Reset values: state=INIT, InitIdx=0, DbgAck=0, DbgRData=0, InitDone=0, latched request fields=0. Stall=1 and RfRegWrite=1 in the first post-reset cycle.
- Init occupies exactly NREG-1 = 31 cycles. InitDone rises on cycle 32 after Reset falls.
- Debug latency: DbgReq seen high in RUN at cycle N → DBG at N+1 → DbgAck=1 from N+2 → RUN one cycle after DbgReq is seen low.
- Exactly one stall cycle per debug access.
- Rf* outputs are combinational from state/latched fields/Dp* inputs. DbgAck, DbgRData and InitDone are registered.
- Reset asserted in any state returns to INIT next edge; DbgAck drops and an in-flight request is discarded.
- Counter never wraps: the INIT exit is decided on equality with NREG-2.

## Structure
- Shared package: state encoding (INIT=2'd0, RUN=2'd1, DBG=2'd2, ACK=2'd3), DATA_W, NREG, XZR index constant 5'd31.
- Single module; the init counter is inline. No sub-module is warranted.
- Output steering is one combinational always block keyed on state. State, counter and latches are in one clocked block.

## Test plan
- Reset then idle 40 cycles → RfRegWrite=1 with RfWriteSelect 0..30 on cycles 1–31, all data 0; Stall=1 through cycle 31; InitDone=1 from cycle 32; index 31 never written.
- After init, DbgReq=1, DbgWrite=1, DbgAddr=5, DbgWData=64'hDEAD_BEEF → exactly one Stall cycle with RfWriteSelect=5 and RfRegWrite=1; DbgAck high next cycle until DbgReq low.
- Debug read of X5 after above → DbgRData=64'hDEAD_BEEF while DbgAck=1; RfRegWrite=0 in DBG even with DpRegWrite=1.
- DbgReq raised at cycle 10 of init → ignored until RUN; DBG occurs on the first cycle after InitDone rises.
- DbgReq held high across ACK for 5 cycles → single access only, no second DBG; datapath writes pass through during ACK.
- Reset asserted during DBG → next cycle state INIT, DbgAck=0, InitIdx=0, clear sequence restarts.
